// File: rtl/stall_data_mem.sv
// Multi-cycle data-memory responder. It accepts a word-aligned read or write,
// holds stall high while the access is in flight, and then pulses done.
// A misaligned request is rejected with a one-cycle err pulse.
module stall_data_mem #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] CntInit   = 4'(LATENCY - 1);
  localparam bit         Immediate = (LATENCY == 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       data_out_q;

  logic [15:0]       mem [2**ADDR_W];

  logic              accept_window;
  logic              accept;
  logic [ADDR_W-1:0] req_idx;
  logic              acc_now;
  logic [ADDR_W-1:0] acc_idx;
  logic [15:0]       acc_data;
  logic              acc_wr;

  // Upper address bits are ignored so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[15:ADDR_W+1];

  // The done cycle doubles as an accept window so back-to-back requests need no bubble.
  assign accept_window = (state_q == StIdle) || done_q;
  assign accept        = rst && accept_window && enable && !addr[0];
  assign req_idx       = addr[ADDR_W:1];
  assign err_d         = rst && accept_window && enable && addr[0];

  // Next-state, counter and access-strobe logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    acc_now  = 1'b0;
    acc_idx  = idx_q;
    acc_data = wdata_q;
    acc_wr   = wr_q;
    if (accept) begin
      state_d = StBusy;
      cnt_d   = CntInit;
      idx_d   = req_idx;
      wdata_d = data_in;
      wr_d    = wr;
      // With a one-cycle latency the access happens on the accepting edge itself.
      if (Immediate) begin
        acc_now  = 1'b1;
        acc_idx  = req_idx;
        acc_data = data_in;
        acc_wr   = wr;
      end
    end else if (state_q == StBusy) begin
      if (done_q) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - 4'd1;
        // The access lands on the edge where the counter reaches zero.
        if (cnt_q == 4'd1) begin
          acc_now = 1'b1;
        end
      end
    end
    done_d = acc_now;
  end

  assign stall = accept || ((state_q == StBusy) && !done_q);

  // Control and output registers; an in-flight request is dropped by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (acc_now && !acc_wr) begin
        data_out_q <= mem[acc_idx];
      end
    end
  end

  // Storage array, not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && acc_now && acc_wr) begin
      mem[acc_idx] <= acc_data;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_stall_data_mem.sv
// Directed bench for stall_data_mem with ADDR_W=10, LATENCY=3.
module tb_stall_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        enable;
  logic        wr;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  stall_data_mem #(
    .ADDR_W (10),
    .LATENCY(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .enable  (enable),
    .wr      (wr),
    .data_out(data_out),
    .stall   (stall),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, check outputs, advance to the next edge.
  task automatic cyc(input string tag, input logic en, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic ex_stall, input logic ex_done,
                     input logic ex_err);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    #1;
    check({tag, ".stall"}, {15'd0, stall}, {15'd0, ex_stall});
    check({tag, ".done"},  {15'd0, done},  {15'd0, ex_done});
    check({tag, ".err"},   {15'd0, err},   {15'd0, ex_err});
    @(posedge clk);
    #1;
  endtask

  // Full isolated transaction: stall in cycles 0..2, done in cycle 3.
  task automatic xfer(input string tag, input logic w, input logic [15:0] a,
                      input logic [15:0] d);
    cyc({tag, ".c0"}, 1'b1, w, a, d, 1'b1, 1'b0, 1'b0);
    cyc({tag, ".c1"}, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc({tag, ".c2"}, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc({tag, ".c3"}, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = 16'h0;
    data_in = 16'h0;
    #1;
    check("rst.stall",    {15'd0, stall}, 16'h0);
    check("rst.done",     {15'd0, done},  16'h0);
    check("rst.err",      {15'd0, err},   16'h0);
    check("rst.data_out", data_out,       16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: write then read back.
    xfer("t1w", 1'b1, 16'h0004, 16'h1234);
    check("t1w.data_out", data_out, 16'h0000);
    xfer("t1r", 1'b0, 16'h0004, 16'h0000);
    check("t1r.data_out", data_out, 16'h1234);

    // 2: read issued in the write's done cycle is accepted back-to-back.
    cyc("t2.c0", 1'b1, 1'b1, 16'h0006, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    cyc("t2.c1", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc("t2.c2", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    wr     = 1'b0;
    addr   = 16'h0006;
    #1;
    check("t2.wdone_data_out", data_out, 16'h1234);
    #0;
    cyc("t2.c3", 1'b1, 1'b0, 16'h0006, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc("t2.c4", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc("t2.c5", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc("t2.c6", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("t2.data_out", data_out, 16'hAAAA);
    cyc("t2.c7", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    // 3: a request pulsed while busy is dropped.
    xfer("t3w", 1'b1, 16'h0008, 16'h0C0C);
    cyc("t3.c0", 1'b1, 1'b0, 16'h0008, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc("t3.c1", 1'b1, 1'b0, 16'h000A, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc("t3.c2", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc("t3.c3", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("t3.data_out", data_out, 16'h0C0C);
    for (int i = 4; i < 8; i++) begin
      cyc($sformatf("t3.c%0d", i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    end

    // 4: misaligned request while idle.
    cyc("t4.c0", 1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc("t4.c1", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    cyc("t4.c2", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc("t4.c3", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t4.data_out", data_out, 16'h0C0C);

    // 5: upper address bits ignored.
    xfer("t5w", 1'b1, 16'h0802, 16'h5A5A);
    xfer("t5r", 1'b0, 16'h0002, 16'h0000);
    check("t5.data_out", data_out, 16'h5A5A);

    // 6: reset aborts an in-flight write.
    xfer("t6w0", 1'b1, 16'h0010, 16'h0000);
    cyc("t6.c0", 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    wr     = 1'b0;
    rst    = 1'b0;
    #1;
    check("t6.rst_stall",    {15'd0, stall}, 16'h0);
    check("t6.rst_done",     {15'd0, done},  16'h0);
    check("t6.rst_data_out", data_out,       16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6.rel_done", {15'd0, done}, 16'h0);
    check("t6.rel_err",  {15'd0, err},  16'h0);
    @(posedge clk);
    #1;
    cyc("t6.idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    xfer("t6r", 1'b0, 16'h0010, 16'h0000);
    check("t6.data_out", data_out, 16'h0000);
    // Make sure the zero above is a real read, not the reset value.
    xfer("t6r2", 1'b0, 16'h0004, 16'h0000);
    check("t6.data_out2", data_out, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
